rtc_param: RTL and testbench
============================

Name: rtc_param

Overview:
- Parametrised next-generation PTP real-time clock: seconds + nanoseconds + sub-ns fraction accumulator.
- Widths are configurable. A nominal period register provides drift compensation. A first-order delta-sigma stage carries the fractional bits that are not kept in the accumulator.
- Multi-cycle slew adjustment runs under a small FSM, with a done pulse. A PPS output is driven from the ns rollover.
- Sits between the host register file and timestamp units; drives time_ptp_* to TSU/PPS logic.

Parameters:
- NS_W, 30, integer ns bits of accumulator.
- NS_FRAC_W, 8, ns fraction bits kept in accumulator.
- PER_INT_W, 8, integer ns bits of period/adjust words.
- PER_FRAC_W, 32, fraction bits of period/adjust words; must be >= NS_FRAC_W.
- SEC_W, 48, seconds width.
- ADJ_CNT_W, 32, slew cycle counter width.
- PPS_CYC, 16, PPS high time in clk cycles; must be >= 1.
- PERIOD_RST, 8 ns (8<<PER_FRAC_W), period_fix reset value.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- time_ld  in  1  direct ToD load strobe.
- time_ns_in  in  NS_W+NS_FRAC_W  ns and fraction to load.
- time_sec_in  in  SEC_W  seconds to load.
- period_ld  in  1  load nominal period.
- period_in  in  PER_INT_W+PER_FRAC_W  nominal per-clk increment.
- time_acc_modulo  in  NS_W+NS_FRAC_W  rollover value, e.g. 1e9 ns<<NS_FRAC_W; 0 disables rollover.
- adj_ld  in  1  start a slew.
- adj_cycles  in  ADJ_CNT_W  number of slewed cycles.
- period_adj  in  PER_INT_W+PER_FRAC_W  signed two's-complement delta added to the period during a slew.
- adj_busy  out  1  high in SLEW state.
- adj_done  out  1  one-cycle pulse when a slew completes.
- time_reg_ns  out  NS_W+NS_FRAC_W  internal ns + fraction.
- time_reg_sec  out  SEC_W  seconds.
- time_ptp_ns  out  32  zero-extended integer ns.
- time_ptp_sec  out  SEC_W  seconds.
- pps  out  1  pulse per rollover.

Behaviour:
- Reset: all outputs are 0. period_fix = PERIOD_RST, FSM = IDLE, delta-sigma residue = 0, PPS counter = 0.
- period_ld: period_fix is updated on the next edge. It is taken at any time, including during SLEW.
- Adjust FSM, IDLE:
  - adj_ld with adj_cycles != 0 loads the counter and latches period_adj, then goes to SLEW.
  - adj_ld with adj_cycles == 0 is ignored: no done pulse.
- Adjust FSM, SLEW:
  - step = period_fix + period_adj_latched. Sum is modulo 2^(PER_INT_W+PER_FRAC_W); a negative result is a programming error.
  - The counter decrements each cycle. On the cycle it reaches 0, go to IDLE and assert adj_done for 1 cycle.
  - adj_ld in SLEW restarts with the new values, with no adj_done for the aborted slew.
- In IDLE, step = period_fix.
- Step register: the step is registered (stage 1).
- Delta-sigma (stage 2): sum = step + residue.
  - Accumulator increment = sum >> (PER_FRAC_W-NS_FRAC_W).
  - residue = low (PER_FRAC_W-NS_FRAC_W) bits of sum.
  - If PER_FRAC_W == NS_FRAC_W, the stage is a plain register.
- Latency: a period_ld or adj_ld at edge N first changes the accumulator increment applied at edge N+3. A slew of K cycles adds exactly K*period_adj to the time, with fractions carried by delta-sigma.
- Accumulator, with nxt = ns + inc:
  - time_ld has priority. It loads ns/sec directly, suppresses rollover and PPS this cycle, and does not clear the residue.
  - Else if modulo != 0 and nxt >= modulo: ns = nxt - modulo, sec = sec + 1 in the SAME cycle, and the PPS counter starts.
  - Else ns = nxt. With modulo == 0, ns wraps modulo 2^(NS_W+NS_FRAC_W) and sec holds.
  - inc >= modulo is unsupported (single subtraction).
  - sec wraps at 2^SEC_W to 0 silently.
- PPS:
  - pps goes high the cycle after the rollover edge and stays high PPS_CYC cycles.
  - A rollover while pps is high restarts the count.
- Outputs are registered; time_ptp_ns = {zeros, ns[NS_W+NS_FRAC_W-1:NS_FRAC_W]}.

Optional Feature:
- Macro RTC_ALARM_EN adds ports alarm_ld (in, 1), alarm_ns (in, NS_W), alarm_sec (in, SEC_W), alarm_clr (in, 1) and alarm (out, 1).
- alarm sets sticky on the first cycle that {sec, integer ns} >= the armed value. It rearms only via alarm_ld.
- alarm_clr clears the flag; alarm_clr has priority over set in the same cycle. alarm resets to 0.
- Without the macro, these ports and the logic are absent.

Decomposition:
- Package rtc_pkg holds: the width localparams derived from the parameters; the FSM state enum {IDLE, SLEW}; and the constant NS_PER_SEC = 1_000_000_000.
- One sub-module, rtc_delta_sigma: holds stage 2 residue logic, parametrised by PER_INT_W, PER_FRAC_W and NS_FRAC_W.

Test Plan:
1. Defaults, period 8 ns, modulo 100<<8, time_ld 0/5 s → ns steps 8/cycle; at the 13th step ns = 4<<8, sec = 6 the same cycle, pps high next cycle for 16 cycles.
2. period_in = 8 ns + 2^23 (1/512 ns) → increment alternates 0x800/0x801; after 1024 cycles total = 8*1024 + 2 ns exactly.
3. adj_ld adj_cycles = 10, period_adj = +1 ns → adj_busy for 10 cycles, adj_done one pulse; final time exceeds the unadjusted run by exactly 10 ns. Repeat with −1 ns → −10 ns.
4. adj_ld again mid-slew (at count 4, new 3 cycles, +2 ns) → no done for the first slew; total offset = 6 ns from the first slew + 6 ns; one adj_done pulse.
5. time_ld coincident with a would-be rollover → loaded values appear, sec not incremented, no pps.
6. modulo = 0 with ns near 2^38 → ns wraps to a small value, sec holds, no pps. With RTC_ALARM_EN: alarm at sec 6, ns 0 asserts on the rollover cycle; simultaneous alarm_clr keeps it 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared widths, FSM encoding and constants for the PTP real-time clock.
// Default widths mirror the rtc_param parameter defaults; instances derive their own from parameters.
package rtc_pkg;

    localparam int NS_W_DEF       = 30;
    localparam int NS_FRAC_W_DEF  = 8;
    localparam int PER_INT_W_DEF  = 8;
    localparam int PER_FRAC_W_DEF = 32;
    localparam int SEC_W_DEF      = 48;
    localparam int ADJ_CNT_W_DEF  = 32;
    localparam int PPS_CYC_DEF    = 16;

    localparam int NS_TOT_W_DEF   = NS_W_DEF + NS_FRAC_W_DEF;
    localparam int PER_W_DEF      = PER_INT_W_DEF + PER_FRAC_W_DEF;
    localparam int DS_SHIFT_DEF   = PER_FRAC_W_DEF - NS_FRAC_W_DEF;

    localparam longint unsigned NS_PER_SEC = 64'd1_000_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        SLEW = 1'b1
    } adj_state_t;

    // Accumulator increment width: period integer + kept fraction + delta-sigma carry.
    function automatic int inc_width(input int per_int_w, input int ns_frac_w);
        return per_int_w + ns_frac_w + 1;
    endfunction

endpackage

// File: rtl/rtc_param_if.sv
// Host/TSU-facing bundle of the real-time clock: load strobes, slew control and time outputs.
// Alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_param_if
    import rtc_pkg::*;
#(
    parameter int NS_W       = NS_W_DEF,
    parameter int NS_FRAC_W  = NS_FRAC_W_DEF,
    parameter int PER_INT_W  = PER_INT_W_DEF,
    parameter int PER_FRAC_W = PER_FRAC_W_DEF,
    parameter int SEC_W      = SEC_W_DEF,
    parameter int ADJ_CNT_W  = ADJ_CNT_W_DEF
);
    logic                            time_ld;
    logic [NS_W+NS_FRAC_W-1:0]       time_ns_in;
    logic [SEC_W-1:0]                time_sec_in;
    logic                            period_ld;
    logic [PER_INT_W+PER_FRAC_W-1:0] period_in;
    logic [NS_W+NS_FRAC_W-1:0]       time_acc_modulo;
    logic                            adj_ld;
    logic [ADJ_CNT_W-1:0]            adj_cycles;
    logic [PER_INT_W+PER_FRAC_W-1:0] period_adj;
    logic                            adj_busy;
    logic                            adj_done;
    logic [NS_W+NS_FRAC_W-1:0]       time_reg_ns;
    logic [SEC_W-1:0]                time_reg_sec;
    logic [31:0]                     time_ptp_ns;
    logic [SEC_W-1:0]                time_ptp_sec;
    logic                            pps;
`ifdef RTC_ALARM_EN
    logic                            alarm_ld;
    logic [NS_W-1:0]                 alarm_ns;
    logic [SEC_W-1:0]                alarm_sec;
    logic                            alarm_clr;
    logic                            alarm;
`endif

    modport master (
        output time_ld, time_ns_in, time_sec_in, period_ld, period_in, time_acc_modulo,
        output adj_ld, adj_cycles, period_adj,
        input  adj_busy, adj_done, time_reg_ns, time_reg_sec, time_ptp_ns, time_ptp_sec, pps
`ifdef RTC_ALARM_EN
        , output alarm_ld, alarm_ns, alarm_sec, alarm_clr
        , input  alarm
`endif
    );

    modport slave (
        input  time_ld, time_ns_in, time_sec_in, period_ld, period_in, time_acc_modulo,
        input  adj_ld, adj_cycles, period_adj,
        output adj_busy, adj_done, time_reg_ns, time_reg_sec, time_ptp_ns, time_ptp_sec, pps
`ifdef RTC_ALARM_EN
        , input  alarm_ld, alarm_ns, alarm_sec, alarm_clr
        , output alarm
`endif
    );

endinterface

// File: rtl/rtc_delta_sigma.sv
// First-order delta-sigma: truncates the period fraction to the kept accumulator fraction, carrying the residue.
// Latency 1 cycle (registered increment); no backpressure, a new step is consumed every cycle.
module rtc_delta_sigma
    import rtc_pkg::*;
#(
    parameter int PER_INT_W  = PER_INT_W_DEF,
    parameter int PER_FRAC_W = PER_FRAC_W_DEF,
    parameter int NS_FRAC_W  = NS_FRAC_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PER_INT_W+PER_FRAC_W-1:0] step,
    output logic [PER_INT_W+NS_FRAC_W:0]    inc
);

    localparam int PER_W = PER_INT_W + PER_FRAC_W;
    localparam int SH    = PER_FRAC_W - NS_FRAC_W;

    generate
        if (SH == 0) begin : g_plain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) inc <= '0;
                else     inc <= {1'b0, step};
            end
        end else begin : g_ds
            logic [SH-1:0] residue;
            logic [PER_W:0] sum;

            assign sum = {1'b0, step} + {{(PER_W + 1 - SH){1'b0}}, residue};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    inc     <= '0;
                    residue <= '0;
                end else begin
                    inc     <= sum[PER_W:SH];
                    residue <= sum[SH-1:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rtc_param.sv
// rtc_param: PTP ToD clock (sec/ns/frac) with drift period, slew FSM and PPS; RTC_ALARM_EN adds a sticky alarm.
// Latency: period/adj load reaches the accumulator 3 edges later; no backpressure, all strobes taken every cycle.
module rtc_param
    import rtc_pkg::*;
#(
    parameter int NS_W       = NS_W_DEF,
    parameter int NS_FRAC_W  = NS_FRAC_W_DEF,
    parameter int PER_INT_W  = PER_INT_W_DEF,
    parameter int PER_FRAC_W = PER_FRAC_W_DEF,
    parameter int SEC_W      = SEC_W_DEF,
    parameter int ADJ_CNT_W  = ADJ_CNT_W_DEF,
    parameter int PPS_CYC    = PPS_CYC_DEF,
    parameter logic [PER_INT_W+PER_FRAC_W-1:0] PERIOD_RST =
        (PER_INT_W + PER_FRAC_W)'(8) << PER_FRAC_W
) (
    input  logic       clk,
    input  logic       rst,
    rtc_param_if.slave bus
);

    localparam int NS_TOT_W   = NS_W + NS_FRAC_W;
    localparam int PER_W      = PER_INT_W + PER_FRAC_W;
    localparam int INC_W      = inc_width(PER_INT_W, NS_FRAC_W);
    localparam int PPS_CNT_W  = $clog2(PPS_CYC + 1);

    logic [PER_W-1:0]     period_fix;
    adj_state_t           state, state_nxt;
    logic [ADJ_CNT_W-1:0] adj_cnt, adj_cnt_nxt;
    logic [PER_W-1:0]     adj_val, adj_val_nxt;
    logic                 done_nxt;
    logic                 adj_done_q;
    logic                 adj_busy_c;
    logic [PER_W-1:0]     step_c, step_q;
    logic [INC_W-1:0]     inc;

    logic [NS_TOT_W-1:0]  ns_q, ns_nxt;
    logic [NS_TOT_W:0]    ns_sum;
    logic [SEC_W-1:0]     sec_q, sec_nxt;
    logic                 roll;
    logic [PPS_CNT_W-1:0] pps_cnt;
    logic                 pps_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                period_fix <= PERIOD_RST;
        else if (bus.period_ld) period_fix <= bus.period_in;
    end

    // Slew FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            adj_cnt    <= '0;
            adj_val    <= '0;
            adj_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            adj_cnt    <= adj_cnt_nxt;
            adj_val    <= adj_val_nxt;
            adj_done_q <= done_nxt;
        end
    end

    // Slew FSM: next state. A reload mid-slew abandons the old one without a done pulse.
    always_comb begin
        state_nxt   = state;
        adj_cnt_nxt = adj_cnt;
        adj_val_nxt = adj_val;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.adj_ld && (bus.adj_cycles != '0)) begin
                    state_nxt   = SLEW;
                    adj_cnt_nxt = bus.adj_cycles;
                    adj_val_nxt = bus.period_adj;
                end
            end
            SLEW: begin
                if (bus.adj_ld) begin
                    if (bus.adj_cycles != '0) begin
                        adj_cnt_nxt = bus.adj_cycles;
                        adj_val_nxt = bus.period_adj;
                    end else begin
                        state_nxt   = IDLE;
                        adj_cnt_nxt = '0;
                    end
                end else if (adj_cnt == ADJ_CNT_W'(1)) begin
                    state_nxt   = IDLE;
                    adj_cnt_nxt = '0;
                    done_nxt    = 1'b1;
                end else begin
                    adj_cnt_nxt = adj_cnt - ADJ_CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slew FSM: outputs
    always_comb begin
        adj_busy_c = (state == SLEW);
        step_c     = adj_busy_c ? (period_fix + adj_val) : period_fix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) step_q <= '0;
        else     step_q <= step_c;
    end

    rtc_delta_sigma #(
        .PER_INT_W  (PER_INT_W),
        .PER_FRAC_W (PER_FRAC_W),
        .NS_FRAC_W  (NS_FRAC_W)
    ) u_ds (
        .clk  (clk),
        .rst  (rst),
        .step (step_q),
        .inc  (inc)
    );

    assign ns_sum = {1'b0, ns_q} + {{(NS_TOT_W + 1 - INC_W){1'b0}}, inc};

    // Rollover compares the unwrapped sum; the low bits of sum - modulo are exact.
    always_comb begin
        ns_nxt  = ns_sum[NS_TOT_W-1:0];
        sec_nxt = sec_q;
        roll    = 1'b0;
        if (bus.time_ld) begin
            ns_nxt  = bus.time_ns_in;
            sec_nxt = bus.time_sec_in;
        end else if ((bus.time_acc_modulo != '0) && (ns_sum >= {1'b0, bus.time_acc_modulo})) begin
            ns_nxt  = ns_sum[NS_TOT_W-1:0] - bus.time_acc_modulo;
            sec_nxt = sec_q + SEC_W'(1);
            roll    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ns_q  <= '0;
            sec_q <= '0;
        end else begin
            ns_q  <= ns_nxt;
            sec_q <= sec_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pps_cnt <= '0;
            pps_q   <= 1'b0;
        end else begin
            pps_q <= (pps_cnt != '0);
            if (roll)                pps_cnt <= PPS_CNT_W'(PPS_CYC);
            else if (pps_cnt != '0)  pps_cnt <= pps_cnt - PPS_CNT_W'(1);
        end
    end

`ifdef RTC_ALARM_EN
    logic             alarm_armed;
    logic             alarm_q;
    logic [SEC_W-1:0] alarm_sec_q;
    logic [NS_W-1:0]  alarm_ns_q;
    logic             alarm_hit;

    // Compared against next-state time so the flag rises with the edge that crosses the mark.
    assign alarm_hit = alarm_armed &&
        ({sec_nxt, ns_nxt[NS_TOT_W-1:NS_FRAC_W]} >= {alarm_sec_q, alarm_ns_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_armed <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_sec_q <= '0;
            alarm_ns_q  <= '0;
        end else begin
            if (bus.alarm_ld) begin
                alarm_armed <= 1'b1;
                alarm_sec_q <= bus.alarm_sec;
                alarm_ns_q  <= bus.alarm_ns;
            end else if (alarm_hit) begin
                alarm_armed <= 1'b0;
            end
            if (bus.alarm_clr)      alarm_q <= 1'b0;
            else if (alarm_hit)     alarm_q <= 1'b1;
        end
    end

    assign bus.alarm = alarm_q;
`endif

    assign bus.adj_busy     = adj_busy_c;
    assign bus.adj_done     = adj_done_q;
    assign bus.time_reg_ns  = ns_q;
    assign bus.time_reg_sec = sec_q;
    assign bus.time_ptp_ns  = 32'(ns_q[NS_TOT_W-1:NS_FRAC_W]);
    assign bus.time_ptp_sec = sec_q;
    assign bus.pps          = pps_q;

endmodule

// File: tb/tb_rtc_param.sv
// Scoreboarded bench for rtc_param: rollover/PPS, fractional period, slews, load priority, modulo-0 wrap.
module tb_rtc_param;
    import rtc_pkg::*;

    localparam int NS_W = 30, NS_FRAC_W = 8, PER_INT_W = 8, PER_FRAC_W = 32;
    localparam int SEC_W = 48, ADJ_CNT_W = 32, PPS_CYC = 16;
    localparam int NS_TOT_W = NS_W + NS_FRAC_W;
    localparam int PER_W = PER_INT_W + PER_FRAC_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rtc_param_if #(
        .NS_W(NS_W), .NS_FRAC_W(NS_FRAC_W), .PER_INT_W(PER_INT_W),
        .PER_FRAC_W(PER_FRAC_W), .SEC_W(SEC_W), .ADJ_CNT_W(ADJ_CNT_W)
    ) bus ();

    rtc_param #(
        .NS_W(NS_W), .NS_FRAC_W(NS_FRAC_W), .PER_INT_W(PER_INT_W),
        .PER_FRAC_W(PER_FRAC_W), .SEC_W(SEC_W), .ADJ_CNT_W(ADJ_CNT_W),
        .PPS_CYC(PPS_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];

    localparam logic [PER_W-1:0] P8    = PER_W'(8) << PER_FRAC_W;
    localparam logic [PER_W-1:0] ONE_NS = PER_W'(1) << PER_FRAC_W;
    localparam logic [NS_TOT_W-1:0] MOD_1S = NS_TOT_W'(NS_PER_SEC * 256);

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [63:0] got);
        if (exp_q.size() == 0) check_val("sb_underflow", 64'(exp_q.size()), 64'd1);
        else                   check_val(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic load_time(input logic [NS_TOT_W-1:0] ns, input logic [SEC_W-1:0] sec);
        bus.time_ld     = 1'b1;
        bus.time_ns_in  = ns;
        bus.time_sec_in = sec;
        tick();
        bus.time_ld = 1'b0;
    endtask

    task automatic load_period(input logic [PER_W-1:0] p);
        bus.period_ld = 1'b1;
        bus.period_in = p;
        tick();
        bus.period_ld = 1'b0;
        ticks(5);
    endtask

    task automatic start_adj(input logic [ADJ_CNT_W-1:0] cyc, input logic [PER_W-1:0] adj);
        bus.adj_ld     = 1'b1;
        bus.adj_cycles = cyc;
        bus.period_adj = adj;
        tick();
        bus.adj_ld = 1'b0;
    endtask

    // Single slew of cyc cycles: 41 edges after the time load, offset exactly cyc*adj.
    task automatic run_slew(input string tag, input int cyc, input logic [PER_W-1:0] adj,
                            input longint off_ns);
        int busy_n, done_n;
        load_time('0, '0);
        sb_push({tag, "_busy"}, 64'(cyc));
        sb_push({tag, "_done"}, 64'd1);
        sb_push({tag, "_ns"}, 64'((8 * 41 + off_ns) * 256));
        start_adj(ADJ_CNT_W'(cyc), adj);
        busy_n = int'(bus.adj_busy);
        done_n = int'(bus.adj_done);
        for (int i = 0; i < 40; i++) begin
            tick();
            busy_n += int'(bus.adj_busy);
            done_n += int'(bus.adj_done);
        end
        sb_pop(64'(busy_n));
        sb_pop(64'(done_n));
        sb_pop(64'(bus.time_reg_ns));
    endtask

    initial begin
        int cnt, busy_n, done_n;
        logic [63:0] a, b, c;
        logic [NS_TOT_W-1:0] near_top;

        bus.time_ld = 0; bus.time_ns_in = '0; bus.time_sec_in = '0;
        bus.period_ld = 0; bus.period_in = '0; bus.time_acc_modulo = '0;
        bus.adj_ld = 0; bus.adj_cycles = '0; bus.period_adj = '0;
`ifdef RTC_ALARM_EN
        bus.alarm_ld = 0; bus.alarm_ns = '0; bus.alarm_sec = '0; bus.alarm_clr = 0;
`endif

        // Reset state
        ticks(3);
        sb_push("rst_ns", 0);   sb_pop(64'(bus.time_reg_ns));
        sb_push("rst_sec", 0);  sb_pop(64'(bus.time_reg_sec));
        sb_push("rst_ptp", 0);  sb_pop(64'(bus.time_ptp_ns));
        sb_push("rst_pps", 0);  sb_pop(64'(bus.pps));
        sb_push("rst_busy", 0); sb_pop(64'(bus.adj_busy));
        sb_push("rst_done", 0); sb_pop(64'(bus.adj_done));
        rst = 1'b0;

        // 1: modulo 100 ns, 8 ns steps, rollover on 13th step, 16-cycle PPS
        bus.time_acc_modulo = NS_TOT_W'(100 * 256);
`ifdef RTC_ALARM_EN
        bus.alarm_ld = 1; bus.alarm_sec = 6; bus.alarm_ns = 0;
        tick();
        bus.alarm_ld = 0;
`endif
        ticks(4);
        sb_push("t1_ld_ns", 0); sb_push("t1_ld_sec", 5);
        load_time('0, SEC_W'(5));
        sb_pop(64'(bus.time_reg_ns)); sb_pop(64'(bus.time_reg_sec));
        sb_push("t1_step12_ns", 96 * 256); sb_push("t1_step12_ptp", 96);
        ticks(12);
        sb_pop(64'(bus.time_reg_ns)); sb_pop(64'(bus.time_ptp_ns));
`ifdef RTC_ALARM_EN
        sb_push("t1_alarm_pre", 0); sb_pop(64'(bus.alarm));
`endif
        sb_push("t1_roll_ns", 4 * 256); sb_push("t1_roll_sec", 6);
        sb_push("t1_roll_ptp_sec", 6); sb_push("t1_roll_pps", 0);
        tick();
        sb_pop(64'(bus.time_reg_ns)); sb_pop(64'(bus.time_reg_sec));
        sb_pop(64'(bus.time_ptp_sec)); sb_pop(64'(bus.pps));
`ifdef RTC_ALARM_EN
        sb_push("t1_alarm_set", 1); sb_pop(64'(bus.alarm));
`endif
        bus.time_acc_modulo = MOD_1S;
        sb_push("t1_pps_rise", 1); sb_push("t1_pps_cycles", PPS_CYC);
        tick();
        sb_pop(64'(bus.pps));
        cnt = int'(bus.pps);
        for (int i = 0; i < 30; i++) begin
            tick();
            cnt += int'(bus.pps);
        end
        sb_pop(64'(cnt));

`ifdef RTC_ALARM_EN
        bus.alarm_clr = 1;
        sb_push("al_clr", 0);
        tick();
        sb_pop(64'(bus.alarm));
        bus.alarm_clr = 0;
        bus.alarm_ld = 1; bus.alarm_sec = 6; bus.alarm_ns = 0;
        tick();
        bus.alarm_ld = 0;
        bus.alarm_clr = 1;
        sb_push("al_clr_prio", 0); sb_push("al_no_rearm", 0);
        tick();
        sb_pop(64'(bus.alarm));
        bus.alarm_clr = 0;
        tick();
        sb_pop(64'(bus.alarm));
`endif

        // 2: period 8 + 1/512 ns over 1024 cycles
        load_period(P8 + (PER_W'(1) << 23));
        sb_push("t2_ns_1024", 8 * 1024 * 256 + 512);
        load_time('0, '0);
        ticks(1024);
        sb_pop(64'(bus.time_reg_ns));
        a = 64'(bus.time_reg_ns); tick();
        b = 64'(bus.time_reg_ns); tick();
        c = 64'(bus.time_reg_ns);
        sb_push("t2_alt_inc", 1);
        sb_pop(64'((((b - a) ^ (c - b)) == 64'd1) && ((c - a) == 64'h1001)));
        load_period(P8);

        // 3: +1 ns and -1 ns slews of 10 cycles
        run_slew("t3_pos", 10, ONE_NS, 10);
        run_slew("t3_neg", 10, PER_W'(0) - ONE_NS, -10);

        // 4: restart after 6 slewed cycles with 3 cycles of +2 ns
        load_time('0, '0);
        sb_push("t4_busy", 9); sb_push("t4_done", 1);
        sb_push("t4_ns", (8 * 47 + 12) * 256);
        start_adj(ADJ_CNT_W'(10), ONE_NS);
        busy_n = int'(bus.adj_busy);
        done_n = int'(bus.adj_done);
        for (int i = 0; i < 5; i++) begin
            tick();
            busy_n += int'(bus.adj_busy);
            done_n += int'(bus.adj_done);
        end
        start_adj(ADJ_CNT_W'(3), ONE_NS << 1);
        busy_n += int'(bus.adj_busy);
        done_n += int'(bus.adj_done);
        for (int i = 0; i < 40; i++) begin
            tick();
            busy_n += int'(bus.adj_busy);
            done_n += int'(bus.adj_done);
        end
        sb_pop(64'(busy_n)); sb_pop(64'(done_n)); sb_pop(64'(bus.time_reg_ns));

        // 5: time_ld on the edge that would roll over
        bus.time_acc_modulo = NS_TOT_W'(100 * 256);
        sb_push("t5_pre_ns", 96 * 256);
        load_time(NS_TOT_W'(96 * 256), SEC_W'(7));
        sb_pop(64'(bus.time_reg_ns));
        sb_push("t5_ld_ns", 50 * 256); sb_push("t5_ld_sec", 20);
        load_time(NS_TOT_W'(50 * 256), SEC_W'(20));
        sb_pop(64'(bus.time_reg_ns)); sb_pop(64'(bus.time_reg_sec));
        sb_push("t5_no_pps", 0); sb_push("t5_no_pps2", 0); sb_push("t5_sec_hold", 20);
        tick(); sb_pop(64'(bus.pps));
        tick(); sb_pop(64'(bus.pps)); sb_pop(64'(bus.time_reg_sec));

        // 6: modulo 0, wrap of the 38-bit accumulator
        bus.time_acc_modulo = '0;
        near_top = NS_TOT_W'(0) - NS_TOT_W'(3 * 256);
        load_time(near_top, SEC_W'(9));
        sb_push("t6_wrap_ns", 5 * 256); sb_push("t6_wrap_sec", 9);
        tick();
        sb_pop(64'(bus.time_reg_ns)); sb_pop(64'(bus.time_reg_sec));
        sb_push("t6_no_pps", 0); sb_push("t6_ns_next", 13 * 256);
        tick();
        sb_pop(64'(bus.pps)); sb_pop(64'(bus.time_reg_ns));

        sb_push("sb_drained", 0);
        sb_pop(64'(exp_q.size() - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
